// File: rtl/mul_pipe_stream.sv
// rtl/mul_pipe_stream.sv - pipelined valid/ready integer multiplier, optional MAC under MUL_PIPE_ACC_EN
// One global advance freezes every stage on an output stall; bubbles are never compressed.
module mul_pipe_stream #(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 8,
   parameter int P_WIDTH   = 24,
   parameter int NUM_STAGE = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] in_a,
   input  logic [B_WIDTH-1:0] in_b,
   input  logic               in_signed,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] out_p,
   output logic               out_last
);

   localparam int DLY = NUM_STAGE - 2;

   logic               advance;
   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] b_q;
   logic               signed_q;
   logic               last_q;
   logic               valid_q;
   logic [A_WIDTH:0]   a_x;
   logic [B_WIDTH:0]   b_x;
   logic [P_WIDTH-1:0] a_p;
   logic [P_WIDTH-1:0] b_p;
   logic [P_WIDTH-1:0] prod;
   logic [P_WIDTH-1:0] feed_p;
   logic               feed_v;
   logic               feed_l;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         last_q   <= 1'b0;
      end else if (advance) begin
         valid_q  <= in_valid;
         a_q      <= in_a;
         b_q      <= in_b;
         signed_q <= in_signed;
         last_q   <= in_last;
      end
   end

   // One extra bit makes both modes a signed multiply; extending to P_WIDTH before
   // multiplying gives exactly the wrapped or sign/zero-extended product.
   assign a_x  = {a_q[A_WIDTH-1] & signed_q, a_q};
   assign b_x  = {b_q[B_WIDTH-1] & signed_q, b_q};
   assign a_p  = P_WIDTH'($signed(a_x));
   assign b_p  = P_WIDTH'($signed(b_x));
   assign prod = a_p * b_p;

   generate
      if (DLY == 0) begin : g_direct
         assign feed_p = prod;
         assign feed_v = valid_q;
         assign feed_l = last_q;
      end else begin : g_delay
         logic [P_WIDTH-1:0] dp [DLY];
         logic [DLY-1:0]     dv;
         logic [DLY-1:0]     dl;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DLY; i++) begin
                  dp[i] <= '0;
               end
               dv <= '0;
               dl <= '0;
            end else if (advance) begin
               dp[0] <= prod;
               dv[0] <= valid_q;
               dl[0] <= last_q;
               for (int i = 1; i < DLY; i++) begin
                  dp[i] <= dp[i-1];
                  dv[i] <= dv[i-1];
                  dl[i] <= dl[i-1];
               end
            end
         end

         assign feed_p = dp[DLY-1];
         assign feed_v = dv[DLY-1];
         assign feed_l = dl[DLY-1];
      end
   endgenerate

`ifdef MUL_PIPE_ACC_EN
   logic [P_WIDTH-1:0] acc;
   logic [P_WIDTH-1:0] acc_sum;

   assign acc_sum = acc + feed_p;

   // Only group-closing beats emit; the accumulator restarts in the same advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_p     <= '0;
         out_last  <= 1'b0;
      end else if (advance) begin
         out_valid <= feed_v && feed_l;
         if (feed_v) begin
            if (feed_l) begin
               out_p    <= acc_sum;
               out_last <= 1'b1;
               acc      <= '0;
            end else begin
               acc <= acc_sum;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_last  <= 1'b0;
      end else if (advance) begin
         out_valid <= feed_v;
         out_p     <= feed_p;
         out_last  <= feed_l;
      end
   end
`endif

endmodule
